// File: rtl/turret_aim_ctrl_if.sv
// Signal bundle between the friend/foe classifier side and the turret aim controller.
// The master drives the per-side class codes; the slave (controller) drives servo, trigger and status.
interface turret_aim_ctrl_if;
    logic [1:0] Ffreq;
    logic [1:0] Sfreq;
    logic       servo_pwm;
    logic       fire;
    logic [1:0] target_side;
    logic       busy;
    logic [2:0] state_dbg;

    modport master (
        output Ffreq, Sfreq,
        input  servo_pwm, fire, target_side, busy, state_dbg
    );

    modport slave (
        input  Ffreq, Sfreq,
        output servo_pwm, fire, target_side, busy, state_dbg
    );
endinterface

// File: rtl/turret_aim_ctrl.sv
// Turret aim controller: confirms a foe over several servo frames, slews the servo toward it,
// fires, holds, then slews back to centre. Generates the 50 Hz servo PWM directly.
module turret_aim_ctrl #(
    parameter int PWM_PERIOD     = 2000000,
    parameter int PULSE_MIN      = 100000,
    parameter int PULSE_CENTER   = 150000,
    parameter int PULSE_MAX      = 200000,
    parameter int STEP           = 2500,
    parameter int CONFIRM_FRAMES = 3,
    parameter int FIRE_FRAMES    = 10,
    parameter int HOLD_FRAMES    = 25
) (
    input  logic               clock,
    input  logic               reset_n,
    turret_aim_ctrl_if.slave   bus
);

    localparam int W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int CW = $clog2(CONFIRM_FRAMES + 1);
    localparam int FW = $clog2(FIRE_FRAMES + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [W-1:0]  FRAME_LAST = W'(PWM_PERIOD - 1);
    localparam logic [W-1:0]  P_MIN      = W'(PULSE_MIN);
    localparam logic [W-1:0]  P_CTR      = W'(PULSE_CENTER);
    localparam logic [W-1:0]  P_MAX      = W'(PULSE_MAX);
    // A step larger than the widest pulse behaves identically, so clamp it to fit W bits.
    localparam logic [W-1:0]  STEP_W     = W'((STEP > PULSE_MAX) ? PULSE_MAX : STEP);
    localparam logic [CW-1:0] CONF_LAST  = CW'(CONFIRM_FRAMES - 1);
    localparam logic [FW-1:0] FIRE_N     = FW'(FIRE_FRAMES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
    localparam bit            DIRECT_AIM = (CONFIRM_FRAMES <= 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONFIRM = 3'd1,
        AIM     = 3'd2,
        FIRE    = 3'd3,
        HOLD    = 3'd4,
        RETURN  = 3'd5
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_frame_cnt;
    logic [W-1:0]  r_pulse_width;
    logic          r_servo_pwm;
    logic          r_fire;
    logic          r_busy;
    logic [1:0]    r_target_side;
    logic [1:0]    r_cand;
    logic [CW-1:0] r_confirm_cnt;
    logic [FW-1:0] r_fire_cnt;
    logic [HW-1:0] r_hold_cnt;

    logic          w_tick;
    logic          w_foe_r;
    logic          w_foe_l;
    logic [1:0]    w_side;
    logic          w_engaged_foe;
    logic [W-1:0]  w_aim_tgt;
    logic [W-1:0]  w_aim_next;
    logic [W-1:0]  w_ret_next;

    // Move cur toward tgt by at most STEP_W, landing exactly on tgt when closer than a step.
    function automatic logic [W-1:0] slew(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W-1:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            slew = (diff > STEP_W) ? cur + STEP_W : tgt;
        end else begin
            diff = cur - tgt;
            slew = (diff > STEP_W) ? cur - STEP_W : tgt;
        end
    endfunction

    assign w_tick        = (r_frame_cnt == FRAME_LAST);
    assign w_foe_r       = (bus.Ffreq == 2'b10);
    assign w_foe_l       = (bus.Sfreq == 2'b10);
    assign w_side        = w_foe_r ? 2'b01 : (w_foe_l ? 2'b10 : 2'b00);
    assign w_engaged_foe = (r_target_side == 2'b10) ? w_foe_l : w_foe_r;
    assign w_aim_tgt     = (r_target_side == 2'b10) ? P_MAX : P_MIN;
    assign w_aim_next    = slew(r_pulse_width, w_aim_tgt);
    assign w_ret_next    = slew(r_pulse_width, P_CTR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_frame_cnt   <= '0;
            r_pulse_width <= P_CTR;
            r_servo_pwm   <= 1'b0;
            r_fire        <= 1'b0;
            r_busy        <= 1'b0;
            r_target_side <= 2'b00;
            r_cand        <= 2'b00;
            r_confirm_cnt <= '0;
            r_fire_cnt    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_frame_cnt <= w_tick ? '0 : r_frame_cnt + 1'b1;
            r_servo_pwm <= (r_frame_cnt < r_pulse_width);

            // Width and state only change at the frame boundary so no pulse is ever cut short.
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_side != 2'b00) begin
                            r_cand <= w_side;
                            r_busy <= 1'b1;
                            if (DIRECT_AIM) begin
                                r_target_side <= w_side;
                                r_state       <= AIM;
                            end else begin
                                r_confirm_cnt <= CW'(1);
                                r_state       <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (w_side == 2'b00) begin
                            r_confirm_cnt <= '0;
                            r_busy        <= 1'b0;
                            r_state       <= IDLE;
                        end else if (w_side != r_cand) begin
                            r_cand        <= w_side;
                            r_confirm_cnt <= CW'(1);
                        end else if (r_confirm_cnt == CONF_LAST) begin
                            r_confirm_cnt <= '0;
                            r_target_side <= r_cand;
                            r_state       <= AIM;
                        end else begin
                            r_confirm_cnt <= r_confirm_cnt + 1'b1;
                        end
                    end
                    AIM: begin
                        if (!w_engaged_foe) begin
                            r_state <= RETURN;
                        end else begin
                            r_pulse_width <= w_aim_next;
                            if (w_aim_next == w_aim_tgt) begin
                                r_fire     <= 1'b1;
                                r_fire_cnt <= FW'(1);
                                r_state    <= FIRE;
                            end
                        end
                    end
                    FIRE: begin
                        if (r_fire_cnt == FIRE_N) begin
                            r_fire     <= 1'b0;
                            r_fire_cnt <= '0;
                            r_hold_cnt <= '0;
                            r_state    <= HOLD;
                        end else begin
                            r_fire_cnt <= r_fire_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_hold_cnt <= '0;
                            r_state    <= RETURN;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    RETURN: begin
                        r_pulse_width <= w_ret_next;
                        if (w_ret_next == P_CTR) begin
                            r_target_side <= 2'b00;
                            r_busy        <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end
                    default: begin
                        r_fire  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.servo_pwm   = r_servo_pwm;
    assign bus.fire        = r_fire;
    assign bus.target_side = r_target_side;
    assign bus.busy        = r_busy;
    assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_turret_aim_ctrl.sv
// Directed bench for turret_aim_ctrl with a shortened servo frame; each step drives the class
// codes mid-frame and checks the state, fire, side and measured pulse width of the next frame.
module tb_turret_aim_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    turret_aim_ctrl_if bus();

    turret_aim_ctrl #(
        .PWM_PERIOD     (100),
        .PULSE_MIN      (10),
        .PULSE_CENTER   (15),
        .PULSE_MAX      (20),
        .STEP           (2),
        .CONFIRM_FRAMES (3),
        .FIRE_FRAMES    (2),
        .HOLD_FRAMES    (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    int         g_w;
    int         g_rise;
    logic [2:0] g_state;
    logic       g_fire;
    logic       g_busy;
    logic [1:0] g_side;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive codes, wait for the next pulse start (just after the frame tick), snapshot status, measure width.
    task automatic frame(input logic [1:0] f, input logic [1:0] s);
        int guard;
        int ok;
        bus.Ffreq = f;
        bus.Sfreq = s;
        ok = 1;
        guard = 0;
        while (bus.servo_pwm !== 1'b0 && guard < 250) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 250) ok = 0;
        guard = 0;
        while (bus.servo_pwm !== 1'b1 && guard < 250) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 250) ok = 0;
        check("pwm_edge", ok, 1);
        g_rise  = cyc;
        g_state = bus.state_dbg;
        g_fire  = bus.fire;
        g_busy  = bus.busy;
        g_side  = bus.target_side;
        g_w     = 0;
        guard   = 0;
        while (bus.servo_pwm === 1'b1 && guard < 250) begin
            g_w++;
            @(negedge clock);
            guard++;
        end
    endtask

    task automatic step(input string tag, input logic [1:0] f, input logic [1:0] s,
                        input int exp_state, input int exp_w, input int exp_fire, input int exp_side);
        frame(f, s);
        check({tag, "_state"}, g_state, exp_state);
        check({tag, "_width"}, g_w, exp_w);
        check({tag, "_fire"}, g_fire, exp_fire);
        check({tag, "_side"}, g_side, exp_side);
        check({tag, "_busy"}, g_busy, (exp_state != 0) ? 1 : 0);
    endtask

    initial begin
        int t0;
        bus.Ffreq = 2'b00;
        bus.Sfreq = 2'b00;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pwm", bus.servo_pwm, 0);
        check("rst_fire", bus.fire, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_side", bus.target_side, 0);
        check("rst_state", bus.state_dbg, 0);
        reset_n = 1'b1;

        // Idle: 15-cycle pulse every 100 cycles
        step("idle0", 2'b00, 2'b00, 0, 15, 0, 0);
        t0 = g_rise;
        step("idle1", 2'b00, 2'b00, 0, 15, 0, 0);
        check("period", g_rise - t0, 100);

        // Right foe: confirm, slew to 10, fire 2 frames, hold 3, slew back
        step("r1",  2'b10, 2'b00, 1, 15, 0, 0);
        step("r2",  2'b10, 2'b00, 1, 15, 0, 0);
        step("r3",  2'b10, 2'b00, 2, 15, 0, 1);
        step("r4",  2'b10, 2'b00, 2, 13, 0, 1);
        step("r5",  2'b10, 2'b00, 2, 11, 0, 1);
        step("r6",  2'b10, 2'b00, 3, 10, 1, 1);
        step("r7",  2'b00, 2'b00, 3, 10, 1, 1);
        step("r8",  2'b00, 2'b00, 4, 10, 0, 1);
        step("r9",  2'b00, 2'b00, 4, 10, 0, 1);
        step("r10", 2'b00, 2'b00, 4, 10, 0, 1);
        step("r11", 2'b00, 2'b00, 5, 10, 0, 1);
        step("r12", 2'b00, 2'b00, 5, 12, 0, 1);
        step("r13", 2'b00, 2'b00, 5, 14, 0, 1);
        step("r14", 2'b00, 2'b00, 0, 15, 0, 0);

        // Foe vanishes during confirm; friend and 11 codes never engage
        step("c1", 2'b10, 2'b00, 1, 15, 0, 0);
        step("c2", 2'b10, 2'b00, 1, 15, 0, 0);
        step("c3", 2'b00, 2'b00, 0, 15, 0, 0);
        step("c4", 2'b01, 2'b00, 0, 15, 0, 0);
        step("c5", 2'b01, 2'b00, 0, 15, 0, 0);
        step("c6", 2'b01, 2'b01, 0, 15, 0, 0);
        step("c7", 2'b11, 2'b11, 0, 15, 0, 0);

        // Foe lost mid-aim: return from 13 without firing
        step("d1", 2'b10, 2'b00, 1, 15, 0, 0);
        step("d2", 2'b10, 2'b00, 1, 15, 0, 0);
        step("d3", 2'b10, 2'b00, 2, 15, 0, 1);
        step("d4", 2'b10, 2'b00, 2, 13, 0, 1);
        step("d5", 2'b00, 2'b00, 5, 13, 0, 1);
        step("d6", 2'b00, 2'b00, 0, 15, 0, 0);

        // Left foe: slew up to 20 and back
        step("l1",  2'b00, 2'b10, 1, 15, 0, 0);
        step("l2",  2'b00, 2'b10, 1, 15, 0, 0);
        step("l3",  2'b00, 2'b10, 2, 15, 0, 2);
        step("l4",  2'b00, 2'b10, 2, 17, 0, 2);
        step("l5",  2'b00, 2'b10, 2, 19, 0, 2);
        step("l6",  2'b00, 2'b10, 3, 20, 1, 2);
        step("l7",  2'b00, 2'b00, 3, 20, 1, 2);
        step("l8",  2'b00, 2'b00, 4, 20, 0, 2);
        step("l9",  2'b00, 2'b00, 4, 20, 0, 2);
        step("l10", 2'b00, 2'b00, 4, 20, 0, 2);
        step("l11", 2'b00, 2'b00, 5, 20, 0, 2);
        step("l12", 2'b00, 2'b00, 5, 18, 0, 2);
        step("l13", 2'b00, 2'b00, 5, 16, 0, 2);
        step("l14", 2'b00, 2'b00, 0, 15, 0, 0);

        // Side switch restarts confirm; both foe resolves to right; then reset during FIRE
        step("b1", 2'b00, 2'b10, 1, 15, 0, 0);
        step("b2", 2'b10, 2'b10, 1, 15, 0, 0);
        step("b3", 2'b10, 2'b10, 1, 15, 0, 0);
        step("b4", 2'b10, 2'b10, 2, 15, 0, 1);
        step("b5", 2'b10, 2'b10, 2, 13, 0, 1);
        step("b6", 2'b10, 2'b10, 2, 11, 0, 1);
        step("b7", 2'b10, 2'b10, 3, 10, 1, 1);
        check("pre_rst_fire", bus.fire, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_fire", bus.fire, 0);
        check("async_rst_state", bus.state_dbg, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_side", bus.target_side, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step("post_rst", 2'b00, 2'b00, 0, 15, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/turret_aim_ctrl.md
Name: turret_aim_ctrl

Overview:
- Downstream consumer of the frequency classifier's per-side friend/foe codes (right sensor = F, left sensor = S).
- Confirms a foe over several servo frames, slews the turret servo toward that side and pulses the fire output.
- Holds on target, then slews back to centre.
- Generates the 50 Hz servo PWM directly; replaces the raw one-hot servo position word.

Parameters:
PWM_PERIOD, 2000000, clock cycles per servo frame (20 ms at 100 MHz)
PULSE_MIN, 100000, high-time in cycles for full-right aim (1.0 ms)
PULSE_CENTER, 150000, high-time for centre/rest (1.5 ms)
PULSE_MAX, 200000, high-time for full-left aim (2.0 ms)
STEP, 2500, maximum change of high-time per frame (slew limit)
CONFIRM_FRAMES, 3, consecutive frames a foe code must persist before aiming
FIRE_FRAMES, 10, frames the fire output stays high
HOLD_FRAMES, 25, frames turret stays on target after firing

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
Ffreq  in  2  right-side class: 00 none, 01 friend, 10 foe, 11 treated as none
Sfreq  in  2  left-side class, same encoding
servo_pwm  out  1  servo control pulse
fire  out  1  trigger drive, high while firing
target_side  out  2  00 none, 01 right, 10 left; latched engaged side
busy  out  1  high in any state other than IDLE
state_dbg  out  3  current FSM state encoding, for LEDs

Behaviour:
- Reset (async, reset_n=0): state IDLE, frame_cnt 0, pulse_width PULSE_CENTER, servo_pwm 0, fire 0, target_side 00, busy 0, all frame counters 0. Deassertion is synchronised; the first frame starts on the first clock after release.
- Frame timer: frame_cnt counts 0..PWM_PERIOD-1 and wraps.
  - servo_pwm registered; high when frame_cnt < pulse_width.
  - "frame tick" = cycle where frame_cnt == PWM_PERIOD-1.
- FSM actions and pulse_width updates occur only on frame tick, so no PWM pulse is ever truncated or stretched mid-frame. Ffreq/Sfreq are sampled only on frame tick.
- Side selection per tick:
  - foe_r = (Ffreq==10), foe_l = (Sfreq==10).
  - Both foe -> right wins.
  - Friend (01) or 11 never engages.
- States: IDLE=0, CONFIRM=1, AIM=2, FIRE=3, HOLD=4, RETURN=5.
  - IDLE: on tick with a foe -> latch candidate side, confirm_cnt=1, go CONFIRM.
  - CONFIRM: tick with same side still foe -> confirm_cnt+1. When count reaches CONFIRM_FRAMES -> target_side=candidate, AIM.
    - Foe vanishes -> IDLE, counter cleared.
    - Foe changes side -> restart with new candidate, count 1.
    - With CONFIRM_FRAMES=1, AIM is entered directly from IDLE on the first foe tick.
  - AIM: target = PULSE_MIN (right) or PULSE_MAX (left).
    - Each tick, pulse_width moves toward target by min(STEP, |target-pulse_width|); never overshoots.
    - When pulse_width == target after the update -> FIRE on the same tick.
    - If the engaged side's code is not foe on a tick -> RETURN, fire stays 0.
  - FIRE: fire=1 for exactly FIRE_FRAMES frames, asserted from the entry tick. Then -> HOLD, fire=0. Input changes are ignored.
  - HOLD: pulse_width held for HOLD_FRAMES frames, inputs ignored, then RETURN.
  - RETURN: slew toward PULSE_CENTER with the same STEP rule. On reaching centre -> IDLE, target_side=00.
- busy = (state != IDLE); state_dbg = state encoding; both registered with the state.
- Widths: pulse_width and frame_cnt sized by clog2(PWM_PERIOD). Slew arithmetic must not underflow or wrap.
- Parameter legality: PULSE_MIN ≤ PULSE_CENTER ≤ PULSE_MAX < PWM_PERIOD, and STEP ≥ 1.
- Reset mid-operation: fire drops immediately (async) and the servo returns to the centre pulse from the next frame. No slew on reset.

Test Plan:
(Bench parameters: PWM_PERIOD=100, PULSE_MIN=10, PULSE_CENTER=15, PULSE_MAX=20, STEP=2, CONFIRM_FRAMES=3, FIRE_FRAMES=2, HOLD_FRAMES=3.)
- Reset then idle inputs 00/00 -> servo_pwm high exactly 15 cycles of every 100; fire=0, busy=0, target_side=00.
- Ffreq=10 held -> CONFIRM for 3 ticks; pulse widths 13, 11, 10 on successive frames (clamped at 10); fire=1 for 2 frames; hold 3 frames; widths 12, 14, 15; then IDLE, target_side 01→00.
- Ffreq=10 and Sfreq=10 together -> target_side=01, servo slews to 10. Sfreq=10 alone -> target_side=10, widths 17, 19, 20.
- Ffreq=10 for 2 ticks then 00 -> returns to IDLE, no aim movement, fire never asserted. Ffreq=01 held -> never leaves IDLE.
- In AIM at width 13, Ffreq→00 -> RETURN; width 15 next tick; fire never high.
- reset_n pulsed low during FIRE -> fire=0 within the same cycle; next frame pulse width is 15; state IDLE.
